// File: rtl/stock_keeper_pkg.sv
// Shared definitions for the vending-machine stock keeper: slot constants,
// refill FSM encoding and the stock_bus field offset helper.
package stock_keeper_pkg;

  localparam int         NUM_SLOTS = 7;
  localparam logic [2:0] SLOT_NONE = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } refill_state_t;

  // Bit offset of a slot's field inside the packed stock bus
  function automatic int slot_offset(input int slot, input int cnt_w);
    return slot * cnt_w;
  endfunction

endpackage

// File: rtl/stock_keeper_lane_counter.sv
// Single goods-lane stock counter: saturates at MAX_STOCK on the way up and
// holds at zero on the way down.
module lane_counter #(
  parameter int CNT_W      = 4,
  parameter int MAX_STOCK  = 15,
  parameter int INIT_STOCK = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_STOCK);
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_STOCK);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  // Simultaneous inc and dec cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= INIT_C;
    end else if (inc && !dec && (count != MAX_C)) begin
      count <= count + ONE_C;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - ONE_C;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == MAX_C);

endmodule

// File: rtl/stock_keeper.sv
// Per-slot inventory controller: edge-detects refill codes, runs the timed
// refill FSM and arbitrates sale requests against the lane counters.
module stock_keeper
  import stock_keeper_pkg::*;
#(
  parameter int MAX_STOCK  = 15,
  parameter int CNT_W      = 4,
  parameter int INIT_STOCK = 0,
  parameter int STEP_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           refill_slot,
  input  logic                 sale_req,
  input  logic [2:0]           sale_slot,
  output logic                 sale_ok,
  output logic                 sale_fail,
  output logic                 refill_busy,
  output logic                 refill_done,
  output logic [2:0]           refill_lane,
  output logic [8*CNT_W-1:0]   stock_bus,
  output logic [7:0]           empty_mask,
  output logic [7:0]           full_mask
);

  localparam int               STEP_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_STOCK);
  localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_STOCK - 1);

  refill_state_t     state_q, state_d;
  logic [2:0]        prev_slot;
  logic [2:0]        lane_q;
  logic [STEP_W-1:0] step_q;
  logic              trig;
  logic              step_last;
  logic              grant;

  logic [CNT_W-1:0]  lane_cnt [1:NUM_SLOTS];
  logic [CNT_W-1:0]  stock    [8];
  logic [NUM_SLOTS:1] lane_empty, lane_full;
  logic [NUM_SLOTS:1] inc_vec, dec_vec;

  assign trig      = (refill_slot != SLOT_NONE) && (refill_slot != prev_slot);
  assign step_last = (step_q == STEP_LAST);

  // Slot 0 always reads as zero stock so lookups by slot code need no guard
  always_comb begin
    stock[0] = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      stock[i] = lane_cnt[i];
    end
  end

  assign grant = sale_req && (sale_slot != SLOT_NONE) && (stock[sale_slot] != '0) &&
                 !(refill_busy && (sale_slot == refill_lane));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_slot <= SLOT_NONE;
    end else begin
      prev_slot <= refill_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = (stock[refill_slot] == MAX_C) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (step_last && (stock[lane_q] == MAX_M1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refill_busy = (state_q == LOAD);
    refill_done = (state_q == DONE);
    refill_lane = (state_q == LOAD) ? lane_q : SLOT_NONE;
  end

  // Triggers outside IDLE are deliberately ignored, so the lane only latches here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= SLOT_NONE;
    end else if ((state_q == IDLE) && trig) begin
      lane_q <= refill_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
    end else if (state_q == LOAD) begin
      step_q <= step_last ? '0 : (step_q + STEP_ONE);
    end else begin
      step_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sale_ok   <= 1'b0;
      sale_fail <= 1'b0;
    end else begin
      sale_ok   <= grant;
      sale_fail <= sale_req && !grant;
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      inc_vec[i] = (state_q == LOAD) && step_last && (lane_q == 3'(i));
      dec_vec[i] = grant && (sale_slot == 3'(i));
    end
  end

  for (genvar g = 1; g <= NUM_SLOTS; g++) begin : g_lane
    lane_counter #(
      .CNT_W      (CNT_W),
      .MAX_STOCK  (MAX_STOCK),
      .INIT_STOCK (INIT_STOCK)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_vec[g]),
      .dec   (dec_vec[g]),
      .count (lane_cnt[g]),
      .empty (lane_empty[g]),
      .full  (lane_full[g])
    );
  end

  always_comb begin
    stock_bus = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      stock_bus[slot_offset(i, CNT_W) +: CNT_W] = lane_cnt[i];
    end
  end

  assign empty_mask = {lane_empty, 1'b0};
  assign full_mask  = {lane_full, 1'b0};

endmodule

// File: tb/tb_stock_keeper.sv
// Directed scoreboard bench for stock_keeper: sale and refill-done responses
// are queued at stimulus time and popped by an independent monitor.
module tb_stock_keeper;

  localparam int CNT_W     = 4;
  localparam int MAX_STOCK = 15;
  localparam int STEP_CYC  = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [2:0]         refill_slot = 3'd0;
  logic               sale_req = 1'b0;
  logic [2:0]         sale_slot = 3'd0;
  logic               sale_ok, sale_fail, refill_busy, refill_done;
  logic [2:0]         refill_lane;
  logic [8*CNT_W-1:0] stock_bus;
  logic [7:0]         empty_mask, full_mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int saleQ[$];
  int doneQ[$];

  stock_keeper #(
    .MAX_STOCK  (MAX_STOCK),
    .CNT_W      (CNT_W),
    .INIT_STOCK (0),
    .STEP_CYC   (STEP_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .refill_slot (refill_slot),
    .sale_req    (sale_req),
    .sale_slot   (sale_slot),
    .sale_ok     (sale_ok),
    .sale_fail   (sale_fail),
    .refill_busy (refill_busy),
    .refill_done (refill_done),
    .refill_lane (refill_lane),
    .stock_bus   (stock_bus),
    .empty_mask  (empty_mask),
    .full_mask   (full_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response pulse must match the oldest queued expectation
  always @(negedge clk) begin
    int e;
    logic [1:0] want;
    if (sale_ok || sale_fail) begin
      checks++;
      if (saleQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sale_unexpected: ok=%0b fail=%0b, required no response", sale_ok, sale_fail);
      end else begin
        e = saleQ.pop_front();
        want = (e != 0) ? 2'b10 : 2'b01;
        if ({sale_ok, sale_fail} !== want) begin
          errors++;
          $display("[TB] FAIL sale_resp: ok/fail=%b, required %b (cycle %0d)", {sale_ok, sale_fail}, want, cyc);
        end
      end
    end
    if (refill_done) begin
      checks++;
      if (doneQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL done_unexpected: refill_done at cycle %0d, required none", cyc);
      end else begin
        e = doneQ.pop_front();
        if (cyc != e) begin
          errors++;
          $display("[TB] FAIL done_timing: refill_done at cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] stockOf(input int s);
    return stock_bus[s*CNT_W +: CNT_W];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of sale inputs (from a negedge) and advance to the next negedge
  task automatic applyStimulus(input logic req, input logic [2:0] slot, input int expOk);
    sale_req  = req;
    sale_slot = slot;
    if (req) saleQ.push_back(expOk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 3'd0, 0);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (!refill_done && n < limit) begin
      applyStimulus(1'b0, 3'd0, 0);
      n++;
    end
    checks++;
    if (!refill_done) begin
      errors++;
      $display("[TB] FAIL done_timeout: refill_done=0 after %0d cycles, required 1", limit);
    end
  endtask

  // Full refill of an empty lane: trig edge + 15*4 LOAD cycles, done seen 61 cycles after the drive
  task automatic refillLane(input logic [2:0] lane);
    refill_slot = lane;
    doneQ.push_back(cyc + 61);
    idle(1);
    waitDone(80);
    idle(1);
    refill_slot = 3'd0;
    idle(1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_stock_bus", stock_bus, 32'h0);
    checkOutput("reset_empty", {24'h0, empty_mask}, 32'hFE);
    checkOutput("reset_full", {24'h0, full_mask}, 32'h00);
    checkOutput("reset_flags", {28'h0, refill_busy, refill_done, sale_ok, sale_fail}, 32'h0);
    checkOutput("reset_lane", {29'h0, refill_lane}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lane 3 refill with code held
    refill_slot = 3'd3;
    doneQ.push_back(cyc + 61);
    idle(1);
    checkOutput("t1_busy", {31'h0, refill_busy}, 32'h1);
    checkOutput("t1_lane", {29'h0, refill_lane}, 32'h3);
    waitDone(80);
    checkOutput("t1_done_busy", {31'h0, refill_busy}, 32'h0);
    idle(1);
    checkOutput("t1_stock3", {28'h0, stockOf(3)}, 32'd15);
    checkOutput("t1_full", {24'h0, full_mask}, 32'h08);
    checkOutput("t1_empty", {24'h0, empty_mask}, 32'hF6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t1_no_retrig", {31'h0, refill_busy}, 32'h0);
      idle(1);
    end
    refill_slot = 3'd0;
    idle(1);

    // Lane 5 down to 2, then ok, ok, fail back-to-back
    refillLane(3'd5);
    repeat (13) applyStimulus(1'b1, 3'd5, 1);
    checkOutput("t2_stock5_2", {28'h0, stockOf(5)}, 32'd2);
    applyStimulus(1'b1, 3'd5, 1);
    applyStimulus(1'b1, 3'd5, 1);
    applyStimulus(1'b1, 3'd5, 0);
    idle(2);
    checkOutput("t2_stock5_0", {28'h0, stockOf(5)}, 32'd0);
    checkOutput("t2_empty5", {31'h0, empty_mask[5]}, 32'h1);

    // Lane 6 to 4 units, lane 4 to full
    refillLane(3'd6);
    repeat (11) applyStimulus(1'b1, 3'd6, 1);
    checkOutput("t3_stock6_4", {28'h0, stockOf(6)}, 32'd4);
    refillLane(3'd4);

    // Lane 2 refill with sales on the busy lane and another lane
    begin
      int c;
      c = cyc;
      refill_slot = 3'd2;
      doneQ.push_back(c + 61);
      idle(1);
      applyStimulus(1'b1, 3'd2, 0);
      while (cyc < c + 8) idle(1);
      checkOutput("t3_stock2_1", {28'h0, stockOf(2)}, 32'd1);
      applyStimulus(1'b1, 3'd6, 1);
      checkOutput("t3_stock2_2", {28'h0, stockOf(2)}, 32'd2);
      checkOutput("t3_stock6_3", {28'h0, stockOf(6)}, 32'd3);
      waitDone(80);
      idle(1);
      checkOutput("t3_stock2_15", {28'h0, stockOf(2)}, 32'd15);
      checkOutput("t3_stock6_end", {28'h0, stockOf(6)}, 32'd3);
      refill_slot = 3'd0;
      idle(1);
    end

    // Refill of an already-full lane
    refill_slot = 3'd4;
    doneQ.push_back(cyc + 1);
    idle(1);
    checkOutput("t4_done", {31'h0, refill_done}, 32'h1);
    checkOutput("t4_busy", {31'h0, refill_busy}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("t4_never_busy", {31'h0, refill_busy}, 32'h0);
    end
    checkOutput("t4_stock4", {28'h0, stockOf(4)}, 32'd15);
    refill_slot = 3'd0;
    idle(1);

    // Lane 7 trigger during lane 1 LOAD is dropped
    refill_slot = 3'd1;
    doneQ.push_back(cyc + 61);
    idle(10);
    refill_slot = 3'd7;
    idle(1);
    checkOutput("t5_lane", {29'h0, refill_lane}, 32'h1);
    waitDone(80);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_no_replay", {31'h0, refill_busy}, 32'h0);
      idle(1);
    end
    checkOutput("t5_stock1", {28'h0, stockOf(1)}, 32'd15);
    checkOutput("t5_stock7", {28'h0, stockOf(7)}, 32'd0);
    applyStimulus(1'b1, 3'd0, 0);
    idle(2);
    refill_slot = 3'd0;
    idle(1);

    // Async reset mid-LOAD on lane 3
    repeat (5) applyStimulus(1'b1, 3'd3, 1);
    idle(1);
    checkOutput("t6_stock3_10", {28'h0, stockOf(3)}, 32'd10);
    refill_slot = 3'd3;
    idle(6);
    checkOutput("t6_busy", {31'h0, refill_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_flags", {28'h0, refill_busy, refill_done, sale_ok, sale_fail}, 32'h0);
    checkOutput("t6_rst_lane", {29'h0, refill_lane}, 32'h0);
    checkOutput("t6_rst_stock", stock_bus, 32'h0);
    checkOutput("t6_rst_empty", {24'h0, empty_mask}, 32'hFE);
    refill_slot = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(70);
    checkOutput("t6_idle_busy", {31'h0, refill_busy}, 32'h0);
    checkOutput("t6_stock3", {28'h0, stockOf(3)}, 32'd0);

    checkOutput("pending_sales", saleQ.size(), 32'd0);
    checkOutput("pending_done", doneQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
